// File: rtl/ahb_mem_slave.sv
// AHB slave memory: word RAM, little-endian byte lanes, write-to-read forwarding, two-cycle ERROR.
// Optional per-beat wait states are built when AHB_MEM_WAIT_EN is defined (WAIT_CYCLES per legal beat).

module ahb_mem_slave_lane (
  input  logic       be,
  input  logic [7:0] wbyte,
  input  logic [7:0] obyte,
  output logic [7:0] mbyte
);
  assign mbyte = be ? wbyte : obyte;
endmodule

module ahb_mem_slave #(
  parameter logic [31:0] START_ADDR     = 32'h0,
  parameter logic [31:0] DEPTH_IN_BYTES = 32'h100,
  parameter int unsigned WAIT_CYCLES    = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADYin,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADYout
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH_IN_BYTES);
  localparam int IW        = AW - 2;
  localparam int NWORDS    = int'(DEPTH_IN_BYTES >> 2);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef struct packed {
    logic                 wr;
    logic [IW-1:0]        idx;
    logic [NUM_LANES-1:0] be;
  } req_t;

`ifdef AHB_MEM_WAIT_EN
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;
  logic [3:0] cnt;
`else
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
`endif

  state_t state;
  req_t   req_q;
  logic [31:0] mem [NWORDS];

  logic [31:0]          off;
  logic                 acc, in_rng, aligned, legal;
  logic [IW-1:0]        acc_idx;
  logic [NUM_LANES-1:0] be_d;
  logic [NUM_LANES-1:0][7:0] wr_old, wr_new;
  logic [31:0]          rd_word;
  logic                 wr_commit;
  logic                 unused_in;

  assign unused_in = ^{HBURST, HTRANS[0], 4'(WAIT_CYCLES)};

  // Range check on the full offset before it is truncated to the RAM index.
  assign off     = HADDR - START_ADDR;
  assign in_rng  = (HADDR >= START_ADDR) && (off < DEPTH_IN_BYTES);
  assign aligned = (HSIZE == 3'd0) ||
                   (HSIZE == 3'd1 && !HADDR[0]) ||
                   (HSIZE == 3'd2 && HADDR[1:0] == 2'b00);
  assign legal   = in_rng && aligned;
  assign acc     = HSEL && HREADYin && HTRANS[1];
  assign acc_idx = off[AW-1:2];

  always_comb begin
    be_d = 4'b1111;
    case (HSIZE[1:0])
      2'd0:    be_d = 4'b0001 << HADDR[1:0];
      2'd1:    be_d = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  assign wr_old = mem[req_q.idx];

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    ahb_mem_slave_lane u_lane (
      .be    (req_q.be[n]),
      .wbyte (HWDATA[8*n +: 8]),
      .obyte (wr_old[n]),
      .mbyte (wr_new[n])
    );
  end

  assign wr_commit = (state == S_DATA) && req_q.wr;

  // A read accepted on the edge that commits a write to the same word sees the merged data.
  assign rd_word = (wr_commit && req_q.idx == acc_idx) ? wr_new : mem[acc_idx];

  always_ff @(posedge HCLK) begin
    if (wr_commit) mem[req_q.idx] <= wr_new;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      req_q     <= '0;
      HRDATA    <= '0;
      HRESP     <= RESP_OKAY;
      HREADYout <= 1'b1;
`ifdef AHB_MEM_WAIT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
`ifdef AHB_MEM_WAIT_EN
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_DATA;
            HREADYout <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`endif
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYout <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all end with HREADYout high: an address phase may land here.
          req_q.wr  <= acc && legal && HWRITE;
          HRDATA    <= '0;
          HRESP     <= RESP_OKAY;
          HREADYout <= 1'b1;
          state     <= S_IDLE;
          if (acc) begin
            req_q.idx <= acc_idx;
            req_q.be  <= be_d;
            if (!legal) begin
              state     <= S_ERR1;
              HRESP     <= RESP_ERR;
              HREADYout <= 1'b0;
            end else begin
              HRDATA <= HWRITE ? 32'h0 : rd_word;
`ifdef AHB_MEM_WAIT_EN
              state     <= S_WAIT;
              HREADYout <= 1'b0;
              cnt       <= 4'(WAIT_CYCLES - 1);
`else
              state     <= S_DATA;
`endif
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: pipelined BFM pushes expected responses, a negedge monitor pops them.
module tb_ahb_mem_slave;
  localparam int WC = 2;
`ifdef AHB_MEM_WAIT_EN
  localparam int WAITS = WC;
`else
  localparam int WAITS = 0;
`endif

  logic        HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = 2'd0;
  logic [2:0]  HSIZE = 3'd2, HBURST = 3'd0;
  logic        HREADYin;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        HREADYout;

  assign HREADYin = HREADYout;
  always #5 HCLK = ~HCLK;

  ahb_mem_slave #(.START_ADDR(32'h0), .DEPTH_IN_BYTES(32'h100), .WAIT_CYCLES(WC)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADYin(HREADYin), .HRDATA(HRDATA), .HRESP(HRESP), .HREADYout(HREADYout)
  );

  typedef struct {
    string       tag;
    logic        chk_d;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;
  logic dp_act = 1'b0;
  int   wcnt = 0, dcyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge HCLK) begin
    exp_t e;
    if (HRESET) begin
      dp_act = 1'b0;
      wcnt   = 0;
      sb.delete();
    end else begin
      if (dp_act) dcyc++;
      if (dp_act && !HREADYout) begin
        wcnt++;
        if (sb.size() > 0) chk({sb[0].tag, "_wresp"}, 32'(HRESP), 32'(sb[0].resp));
      end
      if (dp_act && HREADYout) begin
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk({e.tag, "_resp"}, 32'(HRESP), 32'(e.resp));
          if (e.chk_d) chk({e.tag, "_data"}, HRDATA, e.data);
          chk({e.tag, "_waits"}, 32'(wcnt), (e.resp != 2'b00) ? 32'd1 : 32'(WAITS));
        end
        wcnt = 0;
      end
      if (HREADYout) dp_act = HSEL && HTRANS[1];
    end
  end

  task automatic wait_acc();
    int n = 0;
    forever begin
      @(negedge HCLK);
      if (HREADYout) break;
      if (++n > 40) begin
        chk("hready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic beat(input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [31:0] wdata, input string tag,
                      input logic chk_d, input logic [31:0] exp_d, input logic [1:0] exp_r);
    HSEL = 1'b1; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size;
    if (trans[1]) sb.push_back('{tag, chk_d, exp_d, exp_r});
    wait_acc();
    HWDATA = wdata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                    input string tag, input logic [1:0] r = 2'b00, input logic [1:0] t = 2'd2);
    beat(t, a, 1'b1, s, d, tag, 1'b0, 32'h0, r);
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] s, input logic [31:0] exp_d,
                    input string tag, input logic [1:0] r = 2'b00, input logic [1:0] t = 2'd2,
                    input logic cd = 1'b1);
    beat(t, a, 1'b0, s, 32'h0, tag, cd, exp_d, r);
  endtask

  task automatic idle();
    HTRANS = 2'd0; HWRITE = 1'b0;
    wait_acc();
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge HCLK); #1;
      if (sb.size() == 0 && !dp_act) break;
      if (++n > 60) begin
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (3) begin
      @(negedge HCLK);
      chk("rst_hready", 32'(HREADYout), 32'd1);
      chk("rst_hresp", 32'(HRESP), 32'd0);
      chk("rst_hrdata", HRDATA, 32'h0);
    end
    @(posedge HCLK); #1 HRESET = 1'b0;

    wr(32'h10, 3'd2, 32'hDEAD_BEEF, "w10");
    rd(32'h10, 3'd2, 32'hDEAD_BEEF, "fwd10");
    idle();

    wr(32'h20, 3'd2, 32'h1122_3344, "w20");
    wr(32'h21, 3'd0, 32'hEEEE_A5EE, "wb21");
    rd(32'h20, 3'd2, 32'h1122_A544, "rb20");
    wr(32'h22, 3'd1, 32'h5A5A_EEEE, "wh22");
    rd(32'h20, 3'd2, 32'h5A5A_A544, "rh20");
    idle();

    HBURST = 3'd3;
    for (int i = 0; i < 4; i++)
      wr(32'h40 + 32'(4*i), 3'd2, 32'hC0DE_0000 + 32'(i), "bw", 2'b00, (i == 0) ? 2'd2 : 2'd3);
    idle();
    drain();
    d0 = dcyc;
    for (int i = 0; i < 4; i++)
      rd(32'h40 + 32'(4*i), 3'd2, 32'hC0DE_0000 + 32'(i), "br", 2'b00, (i == 0) ? 2'd2 : 2'd3);
    idle();
    drain();
    chk("burst_cycles", 32'(dcyc - d0), 32'(4 * (WAITS + 1)));
    HBURST = 3'd0;

    wr(32'h00, 3'd2, 32'h1357_9BDF, "w00");
    rd(32'h100, 3'd2, 32'h0, "err_oob", 2'b01);
    idle();
    wr(32'h02, 3'd2, 32'hFFFF_FFFF, "err_mis", 2'b01);
    idle();
    rd(32'h00, 3'd2, 32'h1357_9BDF, "r00");
    rd(32'h01, 3'd1, 32'h0, "err_half", 2'b01);
    idle();
    rd(32'h00, 3'd3, 32'h0, "err_size", 2'b01);
    idle();
    rd(32'hF8, 3'd2, 32'h0, "top0", 2'b00, 2'd2, 1'b0);
    rd(32'hFC, 3'd2, 32'h0, "top1", 2'b00, 2'd3, 1'b0);
    rd(32'h100, 3'd2, 32'h0, "top_err", 2'b01, 2'd3);
    idle();
    drain();

    wr(32'h30, 3'd2, 32'h0BAD_F00D, "w30");
    idle();
    drain();
    wr(32'h30, 3'd2, 32'hFFFF_FFFF, "w30_abort");
    HTRANS = 2'd0;
    @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    chk("arst_hready", 32'(HREADYout), 32'd1);
    chk("arst_hresp", 32'(HRESP), 32'd0);
    chk("arst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    chk("arst_hold_hready", 32'(HREADYout), 32'd1);
    @(posedge HCLK); #1 HRESET = 1'b0;
    rd(32'h30, 3'd2, 32'h0BAD_F00D, "r30_kept");
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
